fpu_exc_handler: RTL
====================

Name: fpu_exc_handler

Overview:
- Response stage that sits after the 8-bit FPU arithmetic core and consumes each completed operation.
- Classifies exception causes from the operands and replaces the result with a canonical NaN when an exception occurs.
- Keeps sticky cause flags and a saturating exception counter, and raises a maskable interrupt.
- Decouples core and consumer with a one-entry registered valid/ready stage.

Parameters:
- CNT_W, 8, width of the saturating exception counter.
- CANON_NAN, 8'h7F, value substituted for RESULT on exception.
- OVERRIDE_EN, 1, 1 = substitute CANON_NAN on exception; 0 = pass RESULT unchanged, flags only.

Ports:
- CLK  input  1  single clock, rising edge.
- RST  input  1  synchronous, active-high reset.
- IN_VALID  input  1  core presents a completed operation.
- IN_READY  output  1  stage can accept; equals !OUT_VALID || OUT_READY.
- FP_OPERATION  input  2  00 add, 01 sub, 10 mul, 11 none.
- OP_A, OP_B  input  8  operands, format sign[7] exp[6:3] mant[2:0].
- RESULT  input  8  raw core result.
- OUT_VALID  output  1  registered result valid.
- OUT_READY  input  1  consumer accepts.
- OUT_RESULT  output  8  final result, possibly overridden.
- OUT_EXC  output  1  exception flag aligned with OUT_RESULT.
- FLAGS  output  3  sticky causes: [0] NaN operand, [1] inf cancellation, [2] zero×inf.
- EXC_COUNT  output  CNT_W  saturating count of excepting transfers.
- IRQ_MASK  input  3  per-cause interrupt enable.
- IRQ  output  1  OR of (FLAGS & IRQ_MASK).
- FLAG_CLR  input  1  one-cycle pulse; clears FLAGS and EXC_COUNT.

Behaviour:
- Reset: the clock is CLK and reset is RST; reset is synchronous and active-high. During RST, OUT_VALID=0, OUT_RESULT=8'h00, OUT_EXC=0, FLAGS=0, EXC_COUNT=0, hence IRQ=0. RST asserted mid-transfer discards the held entry.
- Operand classes:
  - NaN: exp=4'hF and mant!=0.
  - INF: exp=4'hF and mant=0; +INF=8'h78, -INF=8'hF8.
  - ZERO: exp=0 and mant=0, either sign.
- Causes are evaluated on the input operands (combinational):
  - C0: A or B is NaN, for ops 00/01/10.
  - C1:
    - add with one operand +INF and the other -INF;
    - sub with A==B==+INF or A==B==-INF.
  - C2: mul with (ZERO_A and INF_B) or (INF_A and ZERO_B).
  - Op 11: no causes are ever raised.
  - exc = |causes.
- Transfer: occurs when IN_VALID && IN_READY. On a transfer the output register loads next cycle, giving 1-cycle latency:
  - OUT_VALID=1;
  - OUT_EXC=exc;
  - OUT_RESULT = (exc && OVERRIDE_EN) ? CANON_NAN : RESULT.
- Hold: while OUT_VALID && !OUT_READY, the output register and IN_READY=0 are held stable. When OUT_READY=1 with no new transfer, OUT_VALID clears next cycle.
- Throughput: simultaneous drain and transfer gives back-to-back throughput of 1 op/cycle.
- Sticky flags: FLAGS |= causes, updated on transfer (same edge as the output load).
- Counter: EXC_COUNT increments by 1 on each excepting transfer and saturates at 2^CNT_W-1 with no wrap.
- FLAG_CLR:
  - On a cycle with no transfer, FLAGS and EXC_COUNT go to 0.
  - If asserted on the same cycle as an excepting transfer, the set wins: FLAGS = causes of that transfer, EXC_COUNT = 1.
  - FLAG_CLR does not affect the data path.
- IRQ: combinational from the registered FLAGS and IRQ_MASK. Rises the cycle after the transfer that sets a masked-in cause; drops the cycle after clear.
- Protocol rule: no combinational path from IN_VALID to IN_READY.

Decomposition:
- Shared FPU package holds:
  - opcode constants _ADDITION/_SUBTRACTION/_MULTIPLICATION;
  - _PLUS_INF, _MINUS_INF;
  - canonical NaN;
  - field slice positions;
  - cause bit indices.
- One natural sub-module: fpu_exc_cause, purely combinational operand classification producing the 3-bit cause vector.
- The registers, handshake and counters live in fpu_exc_handler.

Test Plan:
1. Add, A=8'h78, B=8'hF8, RESULT=8'h00, OUT_READY=1 → next cycle OUT_VALID=1, OUT_RESULT=8'h7F, OUT_EXC=1, FLAGS=3'b010, EXC_COUNT=1; with IRQ_MASK=3'b010, IRQ=1.
2. Sub:
   - A=B=8'h78 → exception, FLAGS[1]=1.
   - Then sub A=8'hF8, B=8'h78 → no exception, RESULT passed, EXC_COUNT unchanged.
3. Mul:
   - A=8'h80 (-0), B=8'h78 → FLAGS[2]=1.
   - Then mul A=8'h38, B=8'h40 → OUT_RESULT=RESULT, OUT_EXC=0.
   - Then op 11 with NaN operands → no exception.
4. Backpressure: OUT_READY=0 for 3 cycles with IN_VALID held → IN_READY=0, OUT_RESULT stable. Release → each op emerges in order, one per cycle, with none lost or duplicated.
5. Saturation: CNT_W=2, five excepting ops → EXC_COUNT sticks at 3. FLAG_CLR alone → 0. FLAG_CLR coincident with a NaN-operand transfer → FLAGS=3'b001, EXC_COUNT=1.
6. Reset: assert RST while OUT_VALID=1 and FLAGS!=0 → next cycle all outputs 0, IRQ=0. OVERRIDE_EN=0 run of test 1 → OUT_RESULT=8'h00, OUT_EXC=1.

Source files
------------

// File: rtl/fpu_exc_handler_pkg.sv
// Shared definitions for the 8-bit FPU exception response stage:
// opcodes, special encodings, field positions and cause bit indices.
package fpu_exc_handler_pkg;

  localparam logic [1:0] _ADDITION       = 2'b00;
  localparam logic [1:0] _SUBTRACTION    = 2'b01;
  localparam logic [1:0] _MULTIPLICATION = 2'b10;
  localparam logic [1:0] _NO_OPERATION   = 2'b11;

  localparam logic [7:0] _PLUS_INF  = 8'h78;
  localparam logic [7:0] _MINUS_INF = 8'hF8;
  localparam logic [7:0] _CANON_NAN = 8'h7F;

  localparam int EXP_MSB  = 6;
  localparam int EXP_LSB  = 3;
  localparam int MANT_MSB = 2;
  localparam int MANT_LSB = 0;

  localparam int NUM_CAUSES       = 3;
  localparam int CAUSE_NAN        = 0;
  localparam int CAUSE_INF_CANCEL = 1;
  localparam int CAUSE_ZERO_INF   = 2;

  typedef struct packed {
    logic is_nan;
    logic is_inf;
    logic is_zero;
  } fp_class_t;

  // Classification ignores the sign, so callers pass only exponent and mantissa.
  function automatic fp_class_t classify(input logic [EXP_MSB:MANT_LSB] mag);
    fp_class_t                    cls;
    logic [EXP_MSB-EXP_LSB:0]     exp_f;
    logic [MANT_MSB-MANT_LSB:0]   mant_f;
    exp_f       = mag[EXP_MSB:EXP_LSB];
    mant_f      = mag[MANT_MSB:MANT_LSB];
    cls.is_nan  = (&exp_f) && (|mant_f);
    cls.is_inf  = (&exp_f) && !(|mant_f);
    cls.is_zero = !(|exp_f) && !(|mant_f);
    return cls;
  endfunction

endpackage

// File: rtl/fpu_exc_cause.sv
// Combinational operand classification producing the per-cause exception vector.
module fpu_exc_cause
  import fpu_exc_handler_pkg::*;
(
  input  logic [1:0]            fp_operation,
  input  logic [7:0]            op_a,
  input  logic [7:0]            op_b,
  output logic [NUM_CAUSES-1:0] causes
);

  fp_class_t cls_a;
  fp_class_t cls_b;

  assign cls_a = classify(op_a[EXP_MSB:MANT_LSB]);
  assign cls_b = classify(op_b[EXP_MSB:MANT_LSB]);

  // Infinity cancellation is decided on full encodings so the signs come along for free.
  always_comb begin
    causes = '0;
    case (fp_operation)
      _ADDITION:
        causes[CAUSE_INF_CANCEL] = (op_a == _PLUS_INF  && op_b == _MINUS_INF) ||
                                   (op_a == _MINUS_INF && op_b == _PLUS_INF);
      _SUBTRACTION:
        causes[CAUSE_INF_CANCEL] = (op_a == op_b) &&
                                   (op_a == _PLUS_INF || op_a == _MINUS_INF);
      _MULTIPLICATION:
        causes[CAUSE_ZERO_INF]   = (cls_a.is_zero && cls_b.is_inf) ||
                                   (cls_a.is_inf  && cls_b.is_zero);
      default: ;
    endcase
    if (fp_operation != _NO_OPERATION)
      causes[CAUSE_NAN] = cls_a.is_nan || cls_b.is_nan;
  end

endmodule

// File: rtl/fpu_exc_handler.sv
// One-entry registered response stage after the FPU core: result override on
// exception, sticky cause flags, saturating exception counter and maskable IRQ.
module fpu_exc_handler
  import fpu_exc_handler_pkg::*;
#(
  parameter int unsigned CNT_W       = 8,
  parameter logic [7:0]  CANON_NAN   = _CANON_NAN,
  parameter bit          OVERRIDE_EN = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [1:0]            FP_OPERATION,
  input  logic [7:0]            OP_A,
  input  logic [7:0]            OP_B,
  input  logic [7:0]            RESULT,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [7:0]            OUT_RESULT,
  output logic                  OUT_EXC,
  output logic [NUM_CAUSES-1:0] FLAGS,
  output logic [CNT_W-1:0]      EXC_COUNT,
  input  logic [NUM_CAUSES-1:0] IRQ_MASK,
  output logic                  IRQ,
  input  logic                  FLAG_CLR
);

  logic [NUM_CAUSES-1:0] causes;
  logic                  exc;
  logic                  xfer;
  logic [NUM_CAUSES-1:0] flags_base;
  logic [NUM_CAUSES-1:0] flags_next;
  logic [CNT_W-1:0]      count_base;
  logic [CNT_W-1:0]      count_next;

  fpu_exc_cause u_cause (
    .fp_operation (FP_OPERATION),
    .op_a         (OP_A),
    .op_b         (OP_B),
    .causes       (causes)
  );

  assign exc      = |causes;
  // Ready depends only on the output register and the consumer, never on IN_VALID.
  assign IN_READY = !OUT_VALID || OUT_READY;
  assign xfer     = IN_VALID && IN_READY;
  assign IRQ      = |(FLAGS & IRQ_MASK);

  always_ff @(posedge CLK) begin
    if (RST) begin
      OUT_VALID  <= 1'b0;
      OUT_RESULT <= 8'h00;
      OUT_EXC    <= 1'b0;
    end else if (xfer) begin
      OUT_VALID  <= 1'b1;
      OUT_EXC    <= exc;
      OUT_RESULT <= (exc && OVERRIDE_EN) ? CANON_NAN : RESULT;
    end else if (OUT_READY) begin
      OUT_VALID  <= 1'b0;
    end
  end

  // Clear is applied first so a coincident excepting transfer sets on top of it.
  always_comb begin
    flags_base = FLAG_CLR ? '0 : FLAGS;
    count_base = FLAG_CLR ? '0 : EXC_COUNT;
    flags_next = flags_base;
    count_next = count_base;
    if (xfer) begin
      flags_next = flags_base | causes;
      if (exc && !(&count_base))
        count_next = count_base + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      FLAGS     <= '0;
      EXC_COUNT <= '0;
    end else begin
      FLAGS     <= flags_next;
      EXC_COUNT <= count_next;
    end
  end

endmodule
